// File: rtl/imem_program_loader.sv
// Program loader: unpacks a length/data/checksum byte frame into big-endian words,
// writes them sequentially into instruction memory and holds the CPU until a clean load.
module imem_program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter logic [31:0] ADDR_STEP = 32'd1,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] word_buf_q, word_buf_d;
  logic [7:0]  acc_q, acc_d;
  logic        im_we_q, im_we_d;
  logic [31:0] im_addr_q, im_addr_d;
  logic [31:0] im_wdata_q, im_wdata_d;
  logic [15:0] word_count_q, word_count_d;

  logic        xfer;
  logic [15:0] len_next;

  assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CSUM);
  assign xfer     = in_valid && in_ready;
  assign len_next = {len_q[7:0], in_data};

  // Status flags are decoded straight from the state so they can never disagree with it.
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign cpu_hold   = (state_q != S_DONE);
  assign im_we      = im_we_q;
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign word_count = word_count_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d      = state_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    word_buf_d   = word_buf_q;
    acc_d        = acc_q;
    im_we_d      = 1'b0;
    im_addr_d    = im_addr_q;
    im_wdata_d   = im_wdata_q;
    word_count_d = word_count_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_LEN_HI;
          word_count_d = '0;
          acc_d        = '0;
          byte_cnt_d   = '0;
          im_addr_d    = BASE_ADDR;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d   = len_next;
          acc_d   = acc_q ^ in_data;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_next;
          acc_d = acc_q ^ in_data;
          if ({1'b0, len_next} > MaxWords) state_d = S_ERR;
          else if (len_next == 16'd0)      state_d = S_CSUM;
          else                             state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          acc_d      = acc_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            im_we_d      = 1'b1;
            im_wdata_d   = {word_buf_q, in_data};
            // im_addr_q already sits at BASE_ADDR for the first word of a load.
            im_addr_d    = (word_count_q == 16'd0) ? BASE_ADDR : im_addr_q + ADDR_STEP;
            word_count_d = word_count_q + 16'd1;
            if (word_count_q + 16'd1 == len_q) state_d = S_CSUM;
          end else begin
            word_buf_d = {word_buf_q[15:0], in_data};
          end
        end
      end
      S_CSUM: begin
        if (xfer) state_d = (in_data == acc_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      word_buf_q   <= '0;
      acc_q        <= '0;
      im_we_q      <= 1'b0;
      im_addr_q    <= BASE_ADDR;
      im_wdata_q   <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      word_buf_q   <= word_buf_d;
      acc_q        <= acc_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      word_count_q <= word_count_d;
    end
  end

endmodule
